// File: rtl/seq101_scan_ctrl.sv
// seq101_scan_ctrl: serially scans a captured word LSB-first and counts non-overlapping "101" runs.
module seq101_scan_ctrl #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] din,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_count,
  output logic             busy
);
  localparam int IW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  typedef enum logic [1:0] {S0, S1, S10} det_t;
  state_t state_q, state_d;
  det_t det_q, det_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, out_q, out_d, cnt_inc;
  logic bit_c, hit, last;
  always_comb begin
    bit_c   = sr_q[0];
    hit     = (det_q == S10) && bit_c;
    cnt_inc = (hit && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
    last    = idx_q == IW'(WIDTH - 1);
    state_d = state_q;
    det_d   = det_q;
    sr_d    = sr_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    case (state_q)
      IDLE: if (in_valid) begin
        sr_d    = din;
        cnt_d   = '0;
        det_d   = S0;
        idx_d   = '0;
        state_d = SCAN;
      end
      SCAN: begin
        sr_d  = sr_q >> 1;
        idx_d = idx_q + IW'(1);
        cnt_d = cnt_inc;
        // A completed match returns to S0 so its trailing 1 is never reused.
        det_d = bit_c ? ((det_q == S10) ? S0 : S1) : ((det_q == S1) ? S10 : S0);
        if (last) begin
          state_d = DONE;
          out_d   = cnt_inc;
        end
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clear) begin
      state_d = IDLE;
      det_d   = S0;
      cnt_d   = '0;
      out_d   = '0;
      idx_d   = '0;
      sr_d    = '0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      det_q   <= S0;
      sr_q    <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      det_q   <= det_d;
      sr_q    <= sr_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign busy      = state_q != IDLE;
  assign out_count = out_q;
endmodule

// File: tb/tb_seq101_scan_ctrl.sv
// tb_seq101_scan_ctrl: random and directed words checked against a substring-search model of the count.
module tb_seq101_scan_ctrl;
  localparam int W = 16;
  localparam int CW = 4;
  logic clk = 0, rst_n = 0, clear = 0, in_valid = 0, out_ready = 0;
  logic [W-1:0] din = '0;
  logic in_ready, out_valid, busy;
  logic [CW-1:0] out_count;
  int n_cmp = 0, n_bad = 0;

  seq101_scan_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .din(din), .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Leftmost non-overlapping occurrences of bit pattern 1,0,1 reading from bit 0 upward.
  function automatic int model(input logic [W-1:0] w);
    int c = 0;
    int i = 0;
    while (i + 2 < W) begin
      if (w[i] && !w[i+1] && w[i+2]) begin
        c++;
        i += 3;
      end else i++;
    end
    return (c > (1 << CW) - 1) ? (1 << CW) - 1 : c;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [W-1:0] w);
    int k = 0;
    while (!in_ready && k < 50) begin
      step();
      k++;
    end
    chk("in_ready_wait", 32'(in_ready), 32'd1);
    din = w;
    in_valid = 1;
    step();
    in_valid = 0;
    chk("after_accept", 32'({in_ready, busy}), 32'b01);
  endtask

  task automatic run_word(input logic [W-1:0] w, input int exp_i, input int hold, input bit inject);
    logic ir_bad = 0;
    int lat = 0;
    logic [CW-1:0] exp = CW'((exp_i < 0) ? model(w) : exp_i);
    out_ready = (hold == 0);
    accept(w);
    while (!out_valid && lat < 40) begin
      in_valid = inject && (lat == 4);
      din = ~w;
      if (in_ready) ir_bad = 1;
      step();
      lat++;
    end
    in_valid = 0;
    chk("latency", 32'(lat), 32'(W));
    chk("in_ready_low_scan", 32'(ir_bad), 32'd0);
    chk("count", 32'(out_count), 32'(exp));
    chk("in_ready_low_done", 32'(in_ready), 32'd0);
    for (int h = 0; h < hold; h++) begin
      step();
      chk("hold", 32'({out_valid, out_count}), 32'({1'b1, exp}));
    end
    out_ready = 1;
    step();
    chk("post_handshake", 32'({in_ready, out_valid, busy}), 32'b100);
  endtask

  initial begin
    int lat;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", 32'({in_ready, out_valid, busy, out_count}), 32'({3'b100, 4'd0}));
    @(negedge clk);
    rst_n = 1;
    step();
    run_word(16'b1010000000000101, 2, 0, 0);
    run_word(16'b1011011011010101, 5, 0, 0);
    run_word(16'h0000, 0, 0, 0);
    run_word(16'hFFFF, 0, 0, 0);
    run_word(16'h5555, 4, 10, 1);
    accept(16'hA5A5);
    repeat (5) step();
    #2;
    rst_n = 0;
    #1;
    chk("async_reset", 32'({in_ready, out_valid, busy, out_count}), 32'({3'b100, 4'd0}));
    @(negedge clk);
    rst_n = 1;
    step();
    run_word(16'h2DB5, -1, 1, 0);
    accept(16'h1234);
    repeat (7) step();
    clear = 1;
    step();
    clear = 0;
    chk("clear_scan", 32'({in_ready, out_valid, busy, out_count}), 32'({3'b100, 4'd0}));
    run_word(16'b0000000101000101, 2, 0, 0);
    accept(16'h0005);
    lat = 0;
    while (!out_valid && lat < 40) begin
      step();
      lat++;
    end
    chk("clear_done_reach", 32'({out_valid, out_count}), 32'({1'b1, 4'd1}));
    clear = 1;
    out_ready = 1;
    step();
    clear = 0;
    chk("clear_done", 32'({in_ready, out_valid, busy, out_count}), 32'({3'b100, 4'd0}));
    for (int r = 0; r < 20; r++)
      run_word(W'($urandom), -1, int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/seq101_scan_ctrl.md
Name: seq101_scan_ctrl

Overview:
- Sequencing controller for the team's "101" pattern-count datapath.
- Accepts one WIDTH-bit word per transaction over a valid/ready input handshake.
- Scans the word serially, one bit per clock, LSB first, through a non-overlapping "101" detector FSM.
- Returns the match count over a valid/ready output handshake.
- Replaces the combinational loop counter wherever the count feeds clocked logic. It serves one requester at a time and owns the scan from capture to result.

Parameters:
- WIDTH, 16, bits per input word (must be ≥ 3).
- CNT_W, 4, width of the count output (must hold floor(WIDTH/3)).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous abort. Returns to IDLE and discards the word in flight.
- in_valid  input  1  din is valid.
- in_ready  output  1  controller can accept a word (high only in IDLE).
- din  input  WIDTH  word to scan.
- out_valid  output  1  out_count holds a final result.
- out_ready  input  1  consumer accepts the result.
- out_count  output  CNT_W  number of non-overlapping "101" occurrences.
- busy  output  1  high in SCAN or DONE.

Behaviour:
- Clock and reset: single clock domain, clk. rst_n is asynchronous active-low.
- Reset values (while rst_n=0):
  - state=IDLE
  - in_ready=1, out_valid=0, busy=0
  - out_count=0
  - shift register, bit index, detector state and running count all 0.
- Top FSM states: IDLE, SCAN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: capture din into the shift register, clear the running count, detector→S0, index→0, go to SCAN.
- SCAN:
  - Each clock, consume shift_reg[0], shift right, index+1.
  - On the edge consuming bit WIDTH-1: go to DONE, and register out_count with the final count (including a match completed by that bit).
  - in_ready=0 throughout.
- DONE:
  - out_valid=1; out_count is held stable until the handshake.
  - On out_valid&&out_ready: go to IDLE.
  - There is no same-cycle re-accept: in_ready rises the cycle after the handshake.
- Latency: out_valid rises exactly WIDTH clocks after the accepting edge.
- Throughput: one word per WIDTH+2 clocks when out_ready is tied high.
- Detector sub-FSM (advances only in SCAN):
  - S0: bit 1→S1; bit 0→S0.
  - S1: bit 0→S10; bit 1→S1.
  - S10: bit 1→MATCH (count+1, next S0); bit 0→S0.
- Non-overlapping rule: after a match the detector returns to S0, so the final 1 of a match is never reused. Matching is greedy from bit 0 upward. Example: 10101 counts 1, not 2.
- Count arithmetic:
  - Unsigned CNT_W-bit.
  - Cannot overflow when the CNT_W constraint holds.
  - If violated, saturate at all-ones; never wrap.
- Inputs during SCAN/DONE: in_valid is ignored and din is not sampled.
- clear:
  - Synchronous; in any state forces IDLE on the next edge.
  - Clears out_valid, running count and detector; clears out_count to 0.
  - clear has priority over both handshakes in the same cycle.
- Async reset mid-scan: all state returns immediately to reset values; no result is produced.
- busy = (state != IDLE).

Test Plan:
- Reset release, then din=16'b1010000000000101 with in_valid → out_valid high 16 clocks after accept, out_count=2.
- din=16'b1011011011010101 → out_count=5.
- din=16'h5555 → out_count=4 (the overlapping count, 7, must not appear).
- din=16'h0000 and din=16'hFFFF back-to-back with out_ready=1 → both out_count=0; in_ready stays low from accept until the cycle after each output handshake.
- Backpressure and input ignore:
  - Hold out_ready=0 for 10 clocks in DONE → out_valid and out_count stay stable.
  - Assert in_valid with a new din during SCAN → ignored; the first word's result is unchanged.
- Abort and reset:
  - Pulse clear at scan bit 7 → IDLE next edge, out_valid=0, out_count=0; the next word scans correctly.
  - Repeat with rst_n low mid-scan → outputs go to reset values immediately.
